// File: rtl/led_chaser_multi.sv
// ---------------------------------------------------------------------------
// led_chaser_multi
//
// Parametrised running-LED generator. A window of LIT lit LEDs moves across a
// bank of N_LED outputs, advancing once every DIV clock cycles while enabled.
// Four run modes: rotate left, rotate right, bounce and fill.
//
// Parameters:
//   N_LED  number of LED outputs (2..32)
//   LIT    lit LEDs in rotate/bounce modes (1..N_LED-1)
//   DIV    clock cycles per step (>=1)
//
// Ports:
//   clki   in   1      system clock, rising edge
//   rs     in   1      synchronous active-high reset
//   en     in   1      run enable; 0 freezes prescaler and pattern
//   mode   in   2      00 rotate left, 01 rotate right, 10 bounce, 11 fill
//   led    out  N_LED  LED drive (registered pattern), 1 = lit
//   step   out  1      registered pulse, high in the cycle a new led value
//                      first appears
//
// Build option:
//   LED_ACTIVE_LOW_EN  when defined, led is the bitwise inverse of the
//                      internal pattern (sink-driven boards); step unchanged.
// ---------------------------------------------------------------------------
module led_chaser_multi #(
  parameter int N_LED = 8,
  parameter int LIT   = 2,
  parameter int DIV   = 25000000
) (
  input  logic             clki,
  input  logic             rs,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = $clog2(N_LED);
  localparam int FW = $clog2(N_LED + 1);

  localparam logic [CW-1:0]    CNT_LAST   = CW'(DIV - 1);
  localparam logic [PW-1:0]    POS_LAST   = PW'(N_LED - 1);
  localparam logic [PW-1:0]    BOUNCE_TOP = PW'(N_LED - LIT);
  localparam logic [FW-1:0]    FILL_LAST  = FW'(N_LED);
  localparam logic [N_LED-1:0] WINDOW     = N_LED'((64'd1 << LIT) - 64'd1);

  localparam logic [1:0] MODE_ROTL   = 2'b00;
  localparam logic [1:0] MODE_ROTR   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  // Window rotated left by p: the upper half of the doubled vector shifted
  // left carries the bits that wrapped from MSB back to LSB.
  function automatic logic [N_LED-1:0] window_at(input logic [PW-1:0] p);
    logic [2*N_LED-1:0] dbl;
    dbl = {WINDOW, WINDOW} << p;
    return dbl[2*N_LED-1:N_LED];
  endfunction

  // (1 << f) - 1 evaluated one bit wider so f == N_LED gives all ones.
  function automatic logic [N_LED-1:0] fill_pattern(input logic [FW-1:0] f);
    logic [N_LED:0] one_hot;
    logic [N_LED:0] ones;
    one_hot = (N_LED + 1)'(1) << f;
    ones    = one_hot - (N_LED + 1)'(1);
    return ones[N_LED-1:0];
  endfunction

  function automatic logic [N_LED-1:0] reload_pattern(input logic [1:0] m);
    return (m == MODE_FILL) ? '0 : WINDOW;
  endfunction

  logic [CW-1:0]    cnt_q,  cnt_d;
  logic [PW-1:0]    pos_q,  pos_d;
  logic             dir_q,  dir_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [1:0]       mode_q, mode_d;
  logic [N_LED-1:0] pat_q,  pat_d;
  logic             step_q, step_d;
  logic             tick;

  // State register
  always_ff @(posedge clki) begin
    if (rs) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      fill_q <= '0;
      mode_q <= mode;
      pat_q  <= reload_pattern(mode);
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      fill_q <= fill_d;
      mode_q <= mode_d;
      pat_q  <= pat_d;
      step_q <= step_d;
    end
  end

  // Next-state logic
  always_comb begin
    tick   = en && (cnt_q == CNT_LAST);
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    fill_d = fill_q;
    mode_d = mode_q;
    pat_d  = pat_q;
    step_d = 1'b0;

    if (mode != mode_q) begin
      // A mode change restarts the new pattern from scratch; a tick landing
      // on the same edge is dropped so the first step is a full DIV later.
      cnt_d  = '0;
      pos_d  = '0;
      dir_d  = 1'b0;
      fill_d = '0;
      mode_d = mode;
      pat_d  = reload_pattern(mode);
    end else if (tick) begin
      cnt_d  = '0;
      step_d = 1'b1;
      case (mode_q)
        MODE_ROTL: begin
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          pat_d = window_at(pos_d);
        end
        MODE_ROTR: begin
          pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
          pat_d = window_at(pos_d);
        end
        MODE_BOUNCE: begin
          // Direction flips on arrival at an end, so each end shows once.
          if (!dir_q) begin
            pos_d = pos_q + 1'b1;
            dir_d = (pos_d == BOUNCE_TOP);
          end else begin
            pos_d = pos_q - 1'b1;
            dir_d = (pos_d != '0);
          end
          pat_d = window_at(pos_d);
        end
        default: begin
          fill_d = (fill_q == FILL_LAST) ? '0 : fill_q + 1'b1;
          pat_d  = fill_pattern(fill_d);
        end
      endcase
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output logic
  always_comb begin
`ifdef LED_ACTIVE_LOW_EN
    led  = ~pat_q;
`else
    led  = pat_q;
`endif
    step = step_q;
  end

endmodule

// File: tb/tb_led_chaser_multi.sv
// ---------------------------------------------------------------------------
// tb_led_chaser_multi
//
// Directed bench for led_chaser_multi with N_LED=8, LIT=2, DIV=4. Inputs are
// driven and outputs sampled on the falling clock edge. Expected led values
// are written as the lit pattern and converted to the drive polarity of the
// build (LED_ACTIVE_LOW_EN inverts them).
// ---------------------------------------------------------------------------
module tb_led_chaser_multi;

  logic       clki = 1'b0;
  logic       rs;
  logic       en;
  logic [1:0] mode;
  logic [7:0] led;
  logic       step;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] cur;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [7:0] DRIVE_MASK = 8'hFF;
`else
  localparam logic [7:0] DRIVE_MASK = 8'h00;
`endif

  led_chaser_multi #(
    .N_LED (8),
    .LIT   (2),
    .DIV   (4)
  ) dut (
    .clki (clki),
    .rs   (rs),
    .en   (en),
    .mode (mode),
    .led  (led),
    .step (step)
  );

  // Clock / reset block
  always #5 clki = ~clki;

  // Checking tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_led(input string tag, input logic [7:0] pat);
    chk(tag, {24'b0, led}, {24'b0, pat ^ DRIVE_MASK});
  endtask

  // One full step period: three quiet cycles with led held, then the step
  // cycle carrying the new pattern.
  task automatic adv(input string tag, input logic [7:0] nxt);
    for (int i = 0; i < 3; i++) begin
      @(negedge clki);
      chk({tag, "_hold_led"}, {24'b0, led}, {24'b0, cur ^ DRIVE_MASK});
      chk({tag, "_hold_step"}, {31'b0, step}, 32'd0);
    end
    @(negedge clki);
    chk({tag, "_step"}, {31'b0, step}, 32'd1);
    chk_led({tag, "_led"}, nxt);
    cur = nxt;
  endtask

  logic [7:0] rotl_seq   [8]  = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81, 8'h03};
  logic [7:0] bounce_seq [13] = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h60,
                                  8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h06};
  logic [7:0] fill_seq   [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                  8'hFF, 8'h00, 8'h01};

  initial begin
    // Reset, rotate left
    rs   = 1'b1;
    en   = 1'b1;
    mode = 2'b00;
    repeat (5) @(negedge clki);
    chk_led("reset_rotl_led", 8'h03);
    chk("reset_step", {31'b0, step}, 32'd0);
    rs  = 1'b0;
    cur = 8'h03;

    foreach (rotl_seq[i]) adv("rotl", rotl_seq[i]);

    // Enable dropped mid-count: two counts in, freeze ten cycles, then the
    // step arrives after the remaining two counts.
    for (int i = 0; i < 2; i++) begin
      @(negedge clki);
      chk("pre_freeze_step", {31'b0, step}, 32'd0);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clki);
      chk_led("freeze_led", cur);
      chk("freeze_step", {31'b0, step}, 32'd0);
    end
    en = 1'b1;
    @(negedge clki);
    chk("resume_quiet_step", {31'b0, step}, 32'd0);
    @(negedge clki);
    chk("resume_step", {31'b0, step}, 32'd1);
    chk_led("resume_led", 8'h06);
    cur = 8'h06;

    // Mode change to rotate right reloads the window
    mode = 2'b01;
    @(negedge clki);
    chk_led("rotr_reload_led", 8'h03);
    chk("rotr_reload_step", {31'b0, step}, 32'd0);
    cur = 8'h03;
    adv("rotr1", 8'h81);
    adv("rotr2", 8'hC0);

    // Reset asserted mid-pattern
    rs   = 1'b1;
    mode = 2'b00;
    @(negedge clki);
    chk_led("midreset_led", 8'h03);
    chk("midreset_step", {31'b0, step}, 32'd0);
    rs  = 1'b0;
    cur = 8'h03;
    adv("rotl_again", 8'h06);

    // Switch to bounce on the edge that would have ticked
    for (int i = 0; i < 3; i++) begin
      @(negedge clki);
      chk("pre_switch_step", {31'b0, step}, 32'd0);
    end
    mode = 2'b10;
    @(negedge clki);
    chk("switch_on_tick_step", {31'b0, step}, 32'd0);
    chk_led("switch_on_tick_led", 8'h03);
    cur = 8'h03;

    foreach (bounce_seq[i]) adv("bounce", bounce_seq[i]);

    // Fill mode from reset
    rs   = 1'b1;
    mode = 2'b11;
    repeat (2) @(negedge clki);
    chk_led("reset_fill_led", 8'h00);
    rs  = 1'b0;
    cur = 8'h00;

    foreach (fill_seq[i]) adv("fill", fill_seq[i]);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
